// File: rtl/tile_map.sv
// Tile map: a COLS x ROWS register array of tile types with a registered read
// port, a host write port, and an FSM that bulk-loads a level from an external ROM.
module tile_map #(
   parameter int COLS = 8,
   parameter int ROWS = 6,
   parameter int TW = 2,
   parameter int LEVELS = 4,
   parameter logic [TW-1:0] GOAL_TYPE = 2'b10,
   localparam int N = COLS * ROWS,
   localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int AW = (LEVELS * N > 1) ? $clog2(LEVELS * N) : 1,
   localparam int CW = $clog2(N + 1),
   localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_req,
   input  logic [LW-1:0] level_sel,
   output logic [AW-1:0] rom_addr,
   input  logic [TW-1:0] rom_data,
   input  logic [XW-1:0] Xnum,
   input  logic [YW-1:0] Ynum,
   output logic [TW-1:0] Tile_Type,
   input  logic          wr_en,
   input  logic [XW-1:0] wr_x,
   input  logic [YW-1:0] wr_y,
   input  logic [TW-1:0] wr_type,
   output logic          busy,
   output logic          load_done,
   output logic [CW-1:0] goal_count,
   output logic          all_clear,
   output logic [1:0]    fsm_state
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] index_q;
   logic [LW-1:0] level_q;
   logic [CW-1:0] goal_q;
   logic          loaded_q;
   logic [TW-1:0] tiles [N];

   logic          start;
   logic          load_wr;
   logic [IW-1:0] load_idx;
   logic          rd_ok;
   logic [IW-1:0] rd_idx;
   logic          wr_ok;
   logic [IW-1:0] wr_idx;
   logic [TW-1:0] old_type;

   always_comb begin
      state_d   = state_q;
      start     = 1'b0;
      busy      = 1'b0;
      load_done = 1'b0;
      rom_addr  = '0;
      case (state_q)
         IDLE: begin
            if (load_req) begin
               start   = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            busy     = 1'b1;
            rom_addr = AW'(32'(level_q) * N + 32'(index_q));
            if (index_q == IW'(N - 1)) state_d = LAST;
         end
         LAST: begin
            busy    = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            load_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // ROM data lags its address by one cycle, so each FETCH cycle stores the
   // previous index; LAST drains the final tile.
   always_comb begin
      load_wr  = (state_q == FETCH && index_q != '0) || (state_q == LAST);
      load_idx = (state_q == LAST) ? IW'(N - 1) : index_q - IW'(1);
      rd_ok    = (32'(Xnum) < COLS) && (32'(Ynum) < ROWS);
      rd_idx   = IW'(32'(Ynum) * COLS + 32'(Xnum));
      wr_idx   = IW'(32'(wr_y) * COLS + 32'(wr_x));
      wr_ok    = wr_en && (state_q == IDLE) && !load_req &&
                 (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
      old_type = wr_ok ? tiles[wr_idx] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         index_q   <= '0;
         level_q   <= '0;
         goal_q    <= '0;
         loaded_q  <= 1'b0;
         Tile_Type <= '0;
         for (int i = 0; i < N; i++) tiles[i] <= '0;
      end else begin
         state_q   <= state_d;
         Tile_Type <= rd_ok ? tiles[rd_idx] : '0;
         if (start) begin
            level_q <= level_sel;
            index_q <= '0;
            goal_q  <= '0;
         end
         if (state_q == FETCH)
            index_q <= (index_q == IW'(N - 1)) ? '0 : index_q + IW'(1);
         if (load_wr) begin
            tiles[load_idx] <= rom_data;
            if (rom_data == GOAL_TYPE) goal_q <= goal_q + CW'(1);
         end
         // Host writes only happen in IDLE, so they never race a load update.
         if (wr_ok) begin
            tiles[wr_idx] <= wr_type;
            if (old_type != GOAL_TYPE && wr_type == GOAL_TYPE)
               goal_q <= goal_q + CW'(1);
            else if (old_type == GOAL_TYPE && wr_type != GOAL_TYPE)
               goal_q <= goal_q - CW'(1);
         end
         if (state_q == DONE) loaded_q <= 1'b1;
      end
   end

   assign goal_count = goal_q;
   assign all_clear  = (goal_q == '0) && !busy && loaded_q;
   assign fsm_state  = state_q;

endmodule

// File: tb/tb_tile_map.sv
// Directed bench for tile_map: reset, level loads from a ROM model, goal
// collection, port collisions, bounds and mid-load reset abort.
module tb_tile_map;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_req;
   logic [1:0] level_sel;
   logic [7:0] rom_addr;
   logic [1:0] rom_data;
   logic [2:0] Xnum, Ynum, wr_x, wr_y;
   logic [1:0] Tile_Type, wr_type;
   logic       wr_en, busy, load_done, all_clear;
   logic [5:0] goal_count;
   logic [1:0] fsm_state;

   logic [1:0] rom [192];

   int checks = 0;
   int failures = 0;

   tile_map dut (
      .clk(clk), .reset(reset), .load_req(load_req), .level_sel(level_sel),
      .rom_addr(rom_addr), .rom_data(rom_data), .Xnum(Xnum), .Ynum(Ynum),
      .Tile_Type(Tile_Type), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_type(wr_type), .busy(busy), .load_done(load_done),
      .goal_count(goal_count), .all_clear(all_clear), .fsm_state(fsm_state)
   );

   // Clock and synchronous ROM (one cycle of read latency)
   always #5 clk = ~clk;
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // All drivers start and end at a falling edge.
   task automatic rd(input int x, input int y, output logic [1:0] v);
      Xnum = 3'(x);
      Ynum = 3'(y);
      @(negedge clk);
      v = Tile_Type;
   endtask

   task automatic wr(input int x, input int y, input logic [1:0] t);
      wr_en = 1'b1;
      wr_x = 3'(x);
      wr_y = 3'(y);
      wr_type = t;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic nonzero_tiles(output int cnt);
      logic [1:0] v;
      cnt = 0;
      for (int y = 0; y < 6; y++)
         for (int x = 0; x < 8; x++) begin
            rd(x, y, v);
            if (v != 2'b00) cnt++;
         end
   endtask

   // Starts a load; at cycle inj (0 = never) pulses a second load_req and a
   // write to (0,0)=10, both of which must be ignored while busy.
   task automatic run_load(input int lvl, input int inj, output int lat);
      load_req = 1'b1;
      level_sel = 2'(lvl);
      @(negedge clk);
      load_req = 1'b0;
      wr_en = 1'b0;
      lat = 1;
      check("busy_start", busy, 1);
      check("goal_cleared", goal_count, 0);
      check("rom_addr_first", rom_addr, lvl * 48);
      while (!load_done && lat < 200) begin
         if (lat == inj) begin
            load_req = 1'b1;
            level_sel = 2'd0;
            wr_en = 1'b1;
            wr_x = 3'd0;
            wr_y = 3'd0;
            wr_type = 2'b10;
         end
         @(negedge clk);
         load_req = 1'b0;
         wr_en = 1'b0;
         lat++;
      end
      check("load_latency", lat, 50);
      check("done_not_busy", busy, 0);
   endtask

   logic [1:0] v;
   int lat, cnt, seen_done;

   initial begin
      for (int i = 0; i < 192; i++) rom[i] = 2'b00;
      for (int i = 0; i < 48; i++) rom[i] = 2'b10;
      for (int i = 40; i < 46; i++) rom[48 + i] = 2'b01;
      rom[48 + 46] = 2'b10;
      rom[48 + 47] = 2'b10;
      reset = 1'b1; load_req = 1'b0; level_sel = '0; wr_en = 1'b0;
      wr_x = '0; wr_y = '0; wr_type = '0; Xnum = '0; Ynum = '0;

      // Reset
      repeat (2) @(negedge clk);
      check("rst_goal", goal_count, 0);
      check("rst_busy", busy, 0);
      check("rst_all_clear", all_clear, 0);
      check("rst_load_done", load_done, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_tile_type", Tile_Type, 0);
      reset = 1'b0;
      nonzero_tiles(cnt);
      check("rst_tiles_zero", cnt, 0);
      check("rst_no_all_clear_unloaded", all_clear, 0);

      // Load level 1
      run_load(1, 0, lat);
      @(negedge clk);
      check("load_done_pulse", load_done, 0);
      rd(4, 5, v);  check("l1_tile_4_5", v, 2'b01);
      rd(7, 5, v);  check("l1_tile_7_5", v, 2'b10);
      rd(6, 5, v);  check("l1_tile_6_5", v, 2'b10);
      rd(0, 0, v);  check("l1_tile_0_0", v, 2'b00);
      check("l1_goal", goal_count, 2);
      check("l1_all_clear", all_clear, 0);

      // Collect goals
      wr(6, 5, 2'b00);  check("collect_goal_1", goal_count, 1);
      wr(7, 5, 2'b00);  check("collect_goal_0", goal_count, 0);
      check("collect_all_clear", all_clear, 1);
      wr(7, 5, 2'b00);  check("rewrite_goal_0", goal_count, 0);
      wr(0, 0, 2'b10);  check("new_goal_inc", goal_count, 1);
      check("new_goal_not_clear", all_clear, 0);
      wr(0, 0, 2'b11);  check("goal_to_other_dec", goal_count, 0);
      rd(0, 0, v);      check("tile_0_0_is_3", v, 2'b11);

      // Bounds
      rd(7, 6, v);      check("oob_read_7_6", v, 0);
      rd(0, 7, v);      check("oob_read_0_7", v, 0);
      wr(0, 6, 2'b10);  check("oob_write_goal", goal_count, 0);
      rd(0, 0, v);      check("oob_write_no_alias", v, 2'b11);

      // Read and write to the same tile in one cycle returns the old value
      Xnum = 3'd0; Ynum = 3'd0;
      wr(0, 0, 2'b01);  check("rbw_old", Tile_Type, 2'b11);
      rd(0, 0, v);      check("rbw_new", v, 2'b01);

      // load_req with wr_en in IDLE: load wins; busy-time requests ignored
      wr_en = 1'b1; wr_x = 3'd5; wr_y = 3'd0; wr_type = 2'b10;
      run_load(1, 10, lat);
      @(negedge clk);
      check("collide_goal", goal_count, 2);
      rd(0, 0, v);  check("busy_write_ignored", v, 2'b00);
      rd(5, 0, v);  check("idle_write_dropped", v, 2'b00);
      @(negedge clk);
      check("busy_load_ignored", busy, 0);

      // Level 0 fills every tile with the goal type
      run_load(0, 0, lat);
      @(negedge clk);
      check("l0_goal_full", goal_count, 48);
      rd(3, 2, v);      check("l0_tile_3_2", v, 2'b10);
      wr(3, 2, 2'b00);  check("l0_goal_dec", goal_count, 47);

      // Reset in cycle 20 of a load aborts it
      load_req = 1'b1; level_sel = 2'd1;
      @(negedge clk);
      load_req = 1'b0;
      repeat (19) @(negedge clk);
      check("abort_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_goal", goal_count, 0);
      check("abort_rom_addr", rom_addr, 0);
      seen_done = 0;
      for (int i = 0; i < 60; i++) begin
         if (load_done) seen_done = 1;
         @(negedge clk);
      end
      check("abort_no_done", seen_done, 0);
      nonzero_tiles(cnt);
      check("abort_tiles_zero", cnt, 0);
      check("abort_all_clear", all_clear, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
